decode_stage: RTL and testbench

//  Registered RV32I instruction decode stage between fetch and execute.
//  - Decodes every base opcode: full I/S/B/U/J immediate generation, per-opcode alu_op and write-enable.
//  - Passes the PC through; flags illegal encodings.
//  - valid/ready handshake on both sides with a 2-entry skid buffer: full throughput under backpressure.

---
 rtl/decode_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with valid/ready handshake on both sides and a
// 2-entry skid (output register + skid register). Define DECODE_STAGE_MEXT_EN to add muldiv.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instruction,
  input  logic [XLEN-1:0]     pc_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     pc_out,
  output logic [REG_BITS-1:0] rs1,
  output logic [REG_BITS-1:0] rs2,
  output logic [REG_BITS-1:0] rd,
  output logic [XLEN-1:0]     immediate,
  output logic                alu_source,
  output logic [3:0]          alu_op,
  output logic                should_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                jump,
  output logic                illegal
`ifdef DECODE_STAGE_MEXT_EN
  ,
  output logic                muldiv
`endif
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [REG_BITS-1:0] rd;
    logic [XLEN-1:0]     imm;
    logic                alu_source;
    logic [3:0]          alu_op;
    logic                should_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                jump;
    logic                illegal;
`ifdef DECODE_STAGE_MEXT_EN
    logic                muldiv;
`endif
  } bundle_t;

  bundle_t dec, out_q, out_d, skid_q, skid_d;
  logic    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic    in_fire;

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [31:0]      imm32;
  logic [XLEN+31:0] imm_wide;
  logic             wr, bad, rf_bad, use_rs1, use_rs2, use_rd;

  assign opcode = instruction[6:0];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];

  always_comb begin
    dec     = '0;
    imm32   = '0;
    wr      = 1'b0;
    bad     = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    use_rd  = 1'b1;
    dec.pc  = pc_in;
    dec.rs1 = instruction[15 +: REG_BITS];
    dec.rs2 = instruction[20 +: REG_BITS];
    dec.rd  = instruction[7 +: REG_BITS];
    case (opcode)
      OpLui: begin
        dec.rs1        = '0;
        use_rs1        = 1'b0;
        imm32          = {instruction[31:12], 12'b0};
        dec.alu_source = 1'b1;
        wr             = 1'b1;
      end
      OpAuipc: begin
        use_rs1        = 1'b0;
        imm32          = {instruction[31:12], 12'b0};
        dec.alu_source = 1'b1;
        wr             = 1'b1;
      end
      OpJal: begin
        use_rs1        = 1'b0;
        imm32          = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                          instruction[30:21], 1'b0};
        dec.alu_source = 1'b1;
        dec.jump       = 1'b1;
        wr             = 1'b1;
      end
      OpJalr: begin
        imm32          = {{20{instruction[31]}}, instruction[31:20]};
        dec.alu_source = 1'b1;
        dec.jump       = 1'b1;
        wr             = 1'b1;
      end
      OpBranch: begin
        use_rs2    = 1'b1;
        use_rd     = 1'b0;
        imm32      = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                      instruction[11:8], 1'b0};
        dec.alu_op = 4'b1000;
        dec.branch = 1'b1;
      end
      OpLoad: begin
        imm32          = {{20{instruction[31]}}, instruction[31:20]};
        dec.alu_source = 1'b1;
        dec.mem_read   = 1'b1;
        wr             = 1'b1;
      end
      OpStore: begin
        use_rs2        = 1'b1;
        use_rd         = 1'b0;
        imm32          = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        dec.alu_source = 1'b1;
        dec.mem_write  = 1'b1;
      end
      OpImm: begin
        imm32          = {{20{instruction[31]}}, instruction[31:20]};
        dec.alu_source = 1'b1;
        dec.alu_op     = {(f3 == 3'b101) & instruction[30], f3};
        wr             = 1'b1;
      end
      OpReg: begin
        use_rs2 = 1'b1;
        wr      = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.alu_op = {1'b0, f3};
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec.alu_op = {1'b1, f3};
`ifdef DECODE_STAGE_MEXT_EN
        end else if (f7 == 7'b0000001) begin
          dec.alu_op = {1'b0, f3};
          dec.muldiv = 1'b1;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      OpFence, OpSystem: begin
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      end
      default: bad = 1'b1;
    endcase

    imm_wide = {{XLEN{imm32[31]}}, imm32};
    dec.imm  = imm_wide[XLEN-1:0];

    // RV32E: only x0..x15 exist; check just the fields this format really uses.
    rf_bad = (REG_BITS < 5) && ((use_rs1 && instruction[19]) || (use_rs2 && instruction[24]) ||
                                (use_rd && instruction[11]));
    dec.illegal = bad | rf_bad;
    if (dec.illegal) begin
      dec.alu_source = 1'b0;
      dec.alu_op     = 4'b0000;
      dec.mem_read   = 1'b0;
      dec.mem_write  = 1'b0;
      dec.branch     = 1'b0;
      dec.jump       = 1'b0;
      wr             = 1'b0;
`ifdef DECODE_STAGE_MEXT_EN
      dec.muldiv     = 1'b0;
`endif
    end
    dec.should_write = wr && (dec.rd != '0);
  end

  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready && !flush;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_valid_q && !out_ready) begin
      // Output stalled: park the new bundle in the skid slot.
      if (in_fire) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      out_d        = skid_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else begin
      out_valid_d = in_fire;
      if (in_fire) out_d = dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign pc_out       = out_q.pc;
  assign rs1          = out_q.rs1;
  assign rs2          = out_q.rs2;
  assign rd           = out_q.rd;
  assign immediate    = out_q.imm;
  assign alu_source   = out_q.alu_source;
  assign alu_op       = out_q.alu_op;
  assign should_write = out_q.should_write;
  assign mem_read     = out_q.mem_read;
  assign mem_write    = out_q.mem_write;
  assign branch       = out_q.branch;
  assign jump         = out_q.jump;
  assign illegal      = out_q.illegal;
`ifdef DECODE_STAGE_MEXT_EN
  assign muldiv       = out_q.muldiv;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal checks plus randomized traffic against a
// 2-deep FIFO reference model; honours DECODE_STAGE_MEXT_EN.
module tb_decode_stage;

`ifdef DECODE_STAGE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  localparam logic [6:0] OPS [11] = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111,
                                      7'b0100011, 7'b0110011, 7'b0110111, 7'b1100011,
                                      7'b1100111, 7'b1101111, 7'b1110011};

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        alu_source;
    logic [3:0]  alu_op;
    logic        sw, mr, mw, br, jp, ill, md;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instruction, pc_in, pc_out, immediate;
  logic [4:0]  rs1, rs2, rd;
  logic        alu_source, should_write, mem_read, mem_write, branch, jump, illegal, muldiv;
  logic [3:0]  alu_op;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
    .alu_source(alu_source), .alu_op(alu_op), .should_write(should_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .illegal(illegal)
`ifdef DECODE_STAGE_MEXT_EN
    , .muldiv(muldiv)
`endif
  );

`ifndef DECODE_STAGE_MEXT_EN
  assign muldiv = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA field definitions.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic wr;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u = {ins[31:12], 12'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e     = '0;
    e.pc  = pc;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    wr    = 1'b0;
    case (ins[6:0])
      7'b0110111: begin e.rs1 = 5'd0; e.imm = imm_u; e.alu_source = 1'b1; wr = 1'b1; end
      7'b0010111: begin e.imm = imm_u; e.alu_source = 1'b1; wr = 1'b1; end
      7'b1101111: begin e.imm = imm_j; e.alu_source = 1'b1; e.jp = 1'b1; wr = 1'b1; end
      7'b1100111: begin e.imm = imm_i; e.alu_source = 1'b1; e.jp = 1'b1; wr = 1'b1; end
      7'b1100011: begin e.imm = imm_b; e.alu_op = 4'b1000; e.br = 1'b1; end
      7'b0000011: begin e.imm = imm_i; e.alu_source = 1'b1; e.mr = 1'b1; wr = 1'b1; end
      7'b0100011: begin e.imm = imm_s; e.alu_source = 1'b1; e.mw = 1'b1; end
      7'b0010011: begin
        e.imm = imm_i; e.alu_source = 1'b1; wr = 1'b1;
        e.alu_op = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
      end
      7'b0110011: begin
        wr = 1'b1;
        if (f7 == 7'h00) e.alu_op = {1'b0, f3};
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu_op = {1'b1, f3};
        else if (f7 == 7'h01 && MEXT) begin e.alu_op = {1'b0, f3}; e.md = 1'b1; end
        else begin e.ill = 1'b1; wr = 1'b0; end
      end
      7'b0001111, 7'b1110011: e.imm = imm_i;
      default: e.ill = 1'b1;
    endcase
    e.sw = wr && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 9) != 0) w[6:0] = OPS[$urandom_range(0, 10)];
    if (w[6:0] == 7'b0110011) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  // Scoreboard: the stage behaves as a FIFO of depth 2 whose head is the output.
  always @(negedge clk) begin
    int   sz;
    exp_t act;
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_out_valid", out_valid, 1'b0);
    end else begin
      sz = exp_q.size();
      chk("in_ready", in_ready, sz < 2);
      chk("out_valid", out_valid, sz > 0);
      if (sz > 0 && out_valid) begin
        act = {pc_out, rs1, rs2, rd, immediate, alu_source, alu_op, should_write, mem_read,
               mem_write, branch, jump, illegal, muldiv};
        chk("bundle", act, exp_q[0]);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (sz > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && sz < 2) exp_q.push_back(model(instruction, pc_in));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid    = v;
    instruction = ins;
    pc_in       = pc;
    out_ready   = ordy;
    flush       = fl;
  endtask

  // Issue one instruction with out_ready=1 and stop at the negedge where it is presented.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    drive(1'b1, ins, pc, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    exp_t m;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = '0; pc_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_pc_out", pc_out, 32'h0);
    chk("reset_imm", immediate, 32'h0);
    chk("reset_illegal", illegal, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Model pins from hand-encoded instructions.
    m = model(32'hFE000EE3, 32'h0);
    chk("model_beq_imm", m.imm, 32'hFFFFFFFC);
    m = model(32'hFF9FF0EF, 32'h0);
    chk("model_jal_imm", m.imm, 32'hFFFFFFF8);
    m = model(32'h0020A423, 32'h0);
    chk("model_sw_imm", m.imm, 32'h8);

    send(32'hFFF00093, 32'h100);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_rd", rd, 5'd1);
    chk("addi_rs1", rs1, 5'd0);
    chk("addi_imm", immediate, 32'hFFFFFFFF);
    chk("addi_aluop", alu_op, 4'b0000);
    chk("addi_alusrc", alu_source, 1'b1);
    chk("addi_wr", should_write, 1'b1);
    send(32'h0020A423, 32'h104);
    chk("sw_imm", immediate, 32'h8);
    chk("sw_mw", mem_write, 1'b1);
    chk("sw_wr", should_write, 1'b0);
    chk("sw_aluop", alu_op, 4'b0000);
    send(32'h402081B3, 32'h108);
    chk("sub_aluop", alu_op, 4'b1000);
    chk("sub_alusrc", alu_source, 1'b0);
    send(32'h4032D293, 32'h10C);
    chk("srai_aluop", alu_op, 4'b1101);
    send(32'h123450B7, 32'h110);
    chk("lui_imm", immediate, 32'h12345000);
    chk("lui_rs1", rs1, 5'd0);
    send(32'hFE000EE3, 32'h114);
    chk("beq_imm", immediate, 32'hFFFFFFFC);
    chk("beq_branch", branch, 1'b1);
    send(32'hFF9FF0EF, 32'h118);
    chk("jal_imm", immediate, 32'hFFFFFFF8);
    chk("jal_jump", jump, 1'b1);
    send(32'h00000000, 32'h11C);
    chk("zero_illegal", illegal, 1'b1);
    chk("zero_enables", {should_write, mem_read, mem_write, branch, jump}, 5'b0);
    send(32'h0000007F, 32'h120);
    chk("op7f_illegal", illegal, 1'b1);
    send(32'h00000033, 32'h124);
    chk("add_x0_wr", should_write, 1'b0);
    chk("add_x0_illegal", illegal, 1'b0);
    send(32'h023100B3, 32'h128);
    chk("mul_illegal", illegal, !MEXT);
    chk("mul_muldiv", muldiv, MEXT);

    // Backpressure: two fill output+skid, third is refused.
    drive(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
    drive(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
    drive(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head", pc_out, 32'h200);
    drive(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_hold", pc_out, 32'h200);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_second", pc_out, 32'h204);
    chk("bp_ready_back", in_ready, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);

    // Flush with both slots full and a competing input.
    drive(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
    drive(1'b1, 32'h00300193, 32'h308, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream.
    drive(1'b1, 32'hFFF00093, 32'h400, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_pc", pc_out, 32'h0);
    chk("async_rst_imm", immediate, 32'h0);
    chk("async_rst_wr", should_write, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, rand_ins(), $urandom(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
